register_file: RTL and testbench

//  Parametrised multi-entry register bank for the WF8 datapath. Successor to the single-register cells.
//  One write port and two registered read ports (A/B), with optional write-to-read bypass and an optional hardwired-zero entry 0.
//  A per-entry busy scoreboard lets the control unit mark a register as awaiting a result and detect stale reads.

---
 rtl/register_file_pkg.sv | 15 +
 rtl/register_file_read_port.sv | 63 ++++++
 rtl/register_file.sv | 102 ++++++++++
 tb/tb_register_file.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/register_file_pkg.sv
// Shared WF8 defaults and small helpers for the register bank and its read ports.
package register_file_pkg;

  localparam int unsigned WF8_BIT_COUNT = 8;
  localparam int unsigned WF8_REG_COUNT = 4;
  localparam int unsigned WF8_BYPASS    = 1;
  localparam int unsigned WF8_ZERO_REG  = 0;

  // True when an address names a real entry that may be written or reserved.
  function automatic logic addr_writable(input int unsigned addr, input int unsigned reg_count,
                                         input int unsigned zero_reg);
    return (addr < reg_count) && !((zero_reg != 0) && (addr == 0));
  endfunction

endpackage

// File: rtl/register_file_read_port.sv
// One registered read port: range check, hardwired-zero entry and write-to-read bypass.
module register_file_read_port
  import register_file_pkg::*;
#(
  parameter int unsigned BIT_COUNT = WF8_BIT_COUNT,
  parameter int unsigned REG_COUNT = WF8_REG_COUNT,
  parameter int unsigned ADDR_W    = $clog2(WF8_REG_COUNT),
  parameter int unsigned BYPASS    = WF8_BYPASS,
  parameter int unsigned ZERO_REG  = WF8_ZERO_REG
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                clr,
  input  logic [REG_COUNT-1:0][BIT_COUNT-1:0] mem,
  input  logic [REG_COUNT-1:0]                busy,
  input  logic                                wr_ok,
  input  logic [ADDR_W-1:0]                   wr_addr,
  input  logic [BIT_COUNT-1:0]                wr_data,
  input  logic                                rd_en,
  input  logic [ADDR_W-1:0]                   rd_addr,
  output logic [BIT_COUNT-1:0]                rd_data,
  output logic                                rd_valid,
  output logic                                rd_busy
);

  logic                 in_range;
  logic                 is_zero;
  logic                 wr_hit;
  logic [BIT_COUNT-1:0] nxt_data;
  logic                 nxt_busy;

  // Select the value this read would capture at the coming edge.
  always_comb begin
    in_range = 32'(rd_addr) < REG_COUNT;
    is_zero  = (ZERO_REG != 0) && (rd_addr == '0);
    wr_hit   = wr_ok && (wr_addr == rd_addr);
    nxt_data = '0;
    nxt_busy = 1'b0;
    if (in_range && !is_zero) begin
      if ((BYPASS != 0) && wr_hit) begin
        nxt_data = wr_data;
      end else begin
        nxt_data = mem[rd_addr];
        nxt_busy = busy[rd_addr];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_data  <= '0;
      rd_valid <= 1'b0;
      rd_busy  <= 1'b0;
    end else begin
      rd_valid <= rd_en;
      if (rd_en) begin
        rd_data <= clr ? '0 : nxt_data;
        rd_busy <= clr ? 1'b0 : nxt_busy;
      end
    end
  end

endmodule

// File: rtl/register_file.sv
// WF8 register bank: storage, busy scoreboard, write/reserve/clear, and two read ports.
module register_file
  import register_file_pkg::*;
#(
  parameter int unsigned BIT_COUNT = WF8_BIT_COUNT,
  parameter int unsigned REG_COUNT = WF8_REG_COUNT,
  parameter int unsigned BYPASS    = WF8_BYPASS,
  parameter int unsigned ZERO_REG  = WF8_ZERO_REG,
  localparam int unsigned ADDR_W   = $clog2(REG_COUNT)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clr,
  input  logic                 wr_en,
  input  logic [ADDR_W-1:0]    wr_addr,
  input  logic [BIT_COUNT-1:0] wr_data,
  input  logic                 rsv_en,
  input  logic [ADDR_W-1:0]    rsv_addr,
  input  logic                 rd_en_a,
  input  logic [ADDR_W-1:0]    rd_addr_a,
  output logic [BIT_COUNT-1:0] rd_data_a,
  output logic                 rd_valid_a,
  output logic                 rd_busy_a,
  input  logic                 rd_en_b,
  input  logic [ADDR_W-1:0]    rd_addr_b,
  output logic [BIT_COUNT-1:0] rd_data_b,
  output logic                 rd_valid_b,
  output logic                 rd_busy_b,
  output logic [REG_COUNT-1:0] busy
);

  logic [REG_COUNT-1:0][BIT_COUNT-1:0] mem;
  logic                                wr_ok;
  logic                                rsv_ok;

  assign wr_ok  = wr_en  && addr_writable(32'(wr_addr),  REG_COUNT, ZERO_REG);
  assign rsv_ok = rsv_en && addr_writable(32'(rsv_addr), REG_COUNT, ZERO_REG);

  // Reserve is applied after the write so it wins on the same address.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem  <= '0;
      busy <= '0;
    end else if (clr) begin
      mem  <= '0;
      busy <= '0;
    end else begin
      if (wr_ok) begin
        mem[wr_addr]  <= wr_data;
        busy[wr_addr] <= 1'b0;
      end
      if (rsv_ok) begin
        busy[rsv_addr] <= 1'b1;
      end
    end
  end

  register_file_read_port #(
    .BIT_COUNT (BIT_COUNT),
    .REG_COUNT (REG_COUNT),
    .ADDR_W    (ADDR_W),
    .BYPASS    (BYPASS),
    .ZERO_REG  (ZERO_REG)
  ) u_port_a (
    .clk      (clk),
    .rst      (rst),
    .clr      (clr),
    .mem      (mem),
    .busy     (busy),
    .wr_ok    (wr_ok),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .rd_en    (rd_en_a),
    .rd_addr  (rd_addr_a),
    .rd_data  (rd_data_a),
    .rd_valid (rd_valid_a),
    .rd_busy  (rd_busy_a)
  );

  register_file_read_port #(
    .BIT_COUNT (BIT_COUNT),
    .REG_COUNT (REG_COUNT),
    .ADDR_W    (ADDR_W),
    .BYPASS    (BYPASS),
    .ZERO_REG  (ZERO_REG)
  ) u_port_b (
    .clk      (clk),
    .rst      (rst),
    .clr      (clr),
    .mem      (mem),
    .busy     (busy),
    .wr_ok    (wr_ok),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .rd_en    (rd_en_b),
    .rd_addr  (rd_addr_b),
    .rd_data  (rd_data_b),
    .rd_valid (rd_valid_b),
    .rd_busy  (rd_busy_b)
  );

endmodule

// File: tb/tb_register_file.sv
// Directed bench: three register_file configurations driven by one shared stimulus stream.
module tb_register_file;

  logic       clk = 1'b0;
  logic       rst;
  logic       clr;
  logic       wr_en;
  logic [1:0] wr_addr;
  logic [7:0] wr_data;
  logic       rsv_en;
  logic [1:0] rsv_addr;
  logic       rd_en_a;
  logic [1:0] rd_addr_a;
  logic       rd_en_b;
  logic [1:0] rd_addr_b;

  // d0: 4 entries, bypass; d1: 4 entries, no bypass; d2: 3 entries, zero register.
  logic [7:0] data_a0, data_b0, data_a1, data_b1, data_a2, data_b2;
  logic       valid_a0, valid_b0, valid_a1, valid_b1, valid_a2, valid_b2;
  logic       busy_a0, busy_b0, busy_a1, busy_b1, busy_a2, busy_b2;
  logic [3:0] busy0, busy1;
  logic [2:0] busy2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  register_file #(.BIT_COUNT(8), .REG_COUNT(4), .BYPASS(1), .ZERO_REG(0)) d0 (
    .clk(clk), .rst(rst), .clr(clr), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr),
    .rd_en_a(rd_en_a), .rd_addr_a(rd_addr_a), .rd_data_a(data_a0), .rd_valid_a(valid_a0), .rd_busy_a(busy_a0),
    .rd_en_b(rd_en_b), .rd_addr_b(rd_addr_b), .rd_data_b(data_b0), .rd_valid_b(valid_b0), .rd_busy_b(busy_b0),
    .busy(busy0));

  register_file #(.BIT_COUNT(8), .REG_COUNT(4), .BYPASS(0), .ZERO_REG(0)) d1 (
    .clk(clk), .rst(rst), .clr(clr), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr),
    .rd_en_a(rd_en_a), .rd_addr_a(rd_addr_a), .rd_data_a(data_a1), .rd_valid_a(valid_a1), .rd_busy_a(busy_a1),
    .rd_en_b(rd_en_b), .rd_addr_b(rd_addr_b), .rd_data_b(data_b1), .rd_valid_b(valid_b1), .rd_busy_b(busy_b1),
    .busy(busy1));

  register_file #(.BIT_COUNT(8), .REG_COUNT(3), .BYPASS(1), .ZERO_REG(1)) d2 (
    .clk(clk), .rst(rst), .clr(clr), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr),
    .rd_en_a(rd_en_a), .rd_addr_a(rd_addr_a), .rd_data_a(data_a2), .rd_valid_a(valid_a2), .rd_busy_a(busy_a2),
    .rd_en_b(rd_en_b), .rd_addr_b(rd_addr_b), .rd_data_b(data_b2), .rd_valid_b(valid_b2), .rd_busy_b(busy_b2),
    .busy(busy2));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    clr = 1'b0; wr_en = 1'b0; rsv_en = 1'b0; rd_en_a = 1'b0; rd_en_b = 1'b0;
    wr_addr = 2'd0; wr_data = 8'h00; rsv_addr = 2'd0; rd_addr_a = 2'd0; rd_addr_b = 2'd0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    idle();
    #1 rst = 1'b0;
    #2;
    check("reset_data_a", 32'(data_a0), 32'h0);
    check("reset_valid_a", 32'(valid_a0), 32'h0);
    check("reset_busy_a", 32'(busy_a0), 32'h0);
    check("reset_busy", 32'(busy0), 32'h0);
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b1;

    // Basic write then read with one-cycle latency.
    wr_en = 1'b1; wr_addr = 2'd2; wr_data = 8'hA5;
    tick();
    idle();
    wr_en = 1'b1; wr_addr = 2'd1; wr_data = 8'h11;
    rd_en_a = 1'b1; rd_addr_a = 2'd2;
    tick();
    check("read_r2_data", 32'(data_a0), 32'hA5);
    check("read_r2_valid", 32'(valid_a0), 32'h1);
    idle();
    tick();
    check("valid_pulse_drop", 32'(valid_a0), 32'h0);
    check("data_hold", 32'(data_a0), 32'hA5);

    // Same-cycle write and read of r1 on both ports.
    wr_en = 1'b1; wr_addr = 2'd1; wr_data = 8'h3C;
    rd_en_a = 1'b1; rd_addr_a = 2'd1; rd_en_b = 1'b1; rd_addr_b = 2'd1;
    tick();
    check("bypass_a", 32'(data_a0), 32'h3C);
    check("bypass_b", 32'(data_b0), 32'h3C);
    check("nobypass_a", 32'(data_a1), 32'h11);
    check("nobypass_b", 32'(data_b1), 32'h11);
    idle();
    rd_en_a = 1'b1; rd_addr_a = 2'd1;
    tick();
    check("nobypass_reread", 32'(data_a1), 32'h3C);

    // Reserve, stale read, write clears busy.
    idle();
    rsv_en = 1'b1; rsv_addr = 2'd3;
    tick();
    check("reserve_r3_busy", 32'(busy0), 32'h8);
    check("reserve_oor_ignored", 32'(busy2), 32'h0);
    idle();
    rd_en_a = 1'b1; rd_addr_a = 2'd3;
    tick();
    check("stale_busy_a", 32'(busy_a0), 32'h1);
    check("stale_data_a", 32'(data_a0), 32'h0);
    check("oor_read_data", 32'(data_a2), 32'h0);
    check("oor_read_valid", 32'(valid_a2), 32'h1);
    check("oor_read_busy", 32'(busy_a2), 32'h0);
    idle();
    wr_en = 1'b1; wr_addr = 2'd3; wr_data = 8'h07;
    tick();
    check("write_clears_busy", 32'(busy0), 32'h0);
    idle();
    rd_en_a = 1'b1; rd_addr_a = 2'd3;
    tick();
    check("reread_r3_data", 32'(data_a0), 32'h07);
    check("reread_r3_busy", 32'(busy_a0), 32'h0);
    check("oor_write_ignored", 32'(data_a2), 32'h0);

    // Reserve wins over simultaneous write; clear beats write/reserve.
    idle();
    rsv_en = 1'b1; rsv_addr = 2'd2; wr_en = 1'b1; wr_addr = 2'd2; wr_data = 8'h55;
    tick();
    check("rsv_wins_busy", 32'(busy0), 32'h4);
    idle();
    rd_en_a = 1'b1; rd_addr_a = 2'd2;
    tick();
    check("rsv_wr_data", 32'(data_a0), 32'h55);
    check("rsv_wr_rd_busy", 32'(busy_a0), 32'h1);
    idle();
    clr = 1'b1; wr_en = 1'b1; wr_addr = 2'd0; wr_data = 8'h99; rsv_en = 1'b1; rsv_addr = 2'd1;
    rd_en_a = 1'b1; rd_addr_a = 2'd2; rd_en_b = 1'b1; rd_addr_b = 2'd1;
    tick();
    check("clr_busy", 32'(busy0), 32'h0);
    check("clr_read_data", 32'(data_a0), 32'h0);
    check("clr_read_valid", 32'(valid_a0), 32'h1);
    check("clr_read_busy", 32'(busy_a0), 32'h0);
    check("clr_read_b", 32'(data_b0), 32'h0);
    idle();
    rd_en_a = 1'b1; rd_addr_a = 2'd0; rd_en_b = 1'b1; rd_addr_b = 2'd2;
    tick();
    check("clr_write_dropped", 32'(data_a0), 32'h0);
    check("clr_entry_zero", 32'(data_b0), 32'h0);

    // Zero register discards write and reserve; normal bank keeps them.
    idle();
    wr_en = 1'b1; wr_addr = 2'd0; wr_data = 8'hFF; rsv_en = 1'b1; rsv_addr = 2'd0;
    tick();
    check("zero_reg_busy", 32'(busy2), 32'h0);
    check("r0_rsv_busy", 32'(busy0), 32'h1);
    idle();
    rd_en_a = 1'b1; rd_addr_a = 2'd0;
    tick();
    check("zero_reg_data", 32'(data_a2), 32'h0);
    check("zero_reg_rd_busy", 32'(busy_a2), 32'h0);
    check("r0_data", 32'(data_a0), 32'hFF);
    check("r0_rd_busy", 32'(busy_a0), 32'h1);

    // Asynchronous reset mid-cycle with busy set and reads in flight.
    idle();
    rsv_en = 1'b1; rsv_addr = 2'd2;
    rd_en_a = 1'b1; rd_addr_a = 2'd0; rd_en_b = 1'b1; rd_addr_b = 2'd0;
    tick();
    check("pre_rst_busy", 32'(busy0), 32'h5);
    check("pre_rst_data", 32'(data_b0), 32'hFF);
    #2 rst = 1'b0;
    #1;
    check("async_rst_data_a", 32'(data_a0), 32'h0);
    check("async_rst_valid_a", 32'(valid_a0), 32'h0);
    check("async_rst_busy_a", 32'(busy_a0), 32'h0);
    check("async_rst_data_b", 32'(data_b0), 32'h0);
    check("async_rst_valid_b", 32'(valid_b0), 32'h0);
    check("async_rst_busy", 32'(busy0), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
